// File: rtl/nios2_debug_pkg.sv
// Shared types and field positions for the system-clock half of the JTAG debug slave.
package nios2_debug_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } dbg_state_t;

    localparam int DEF_SR_W      = 38;
    localparam int DEF_OP_OCIMEM = 0;
    localparam int DEF_OP_BREAK  = 2;
    localparam int DEF_OP_TRACE  = 3;

    // The mode/channel field sits in the top two bits, T and S just below it
    function automatic int mode_msb(input int sr_w);
        return sr_w - 1;
    endfunction

    function automatic int mode_lsb(input int sr_w);
        return sr_w - 2;
    endfunction

    function automatic int t_bit(input int sr_w);
        return sr_w - 3;
    endfunction

    function automatic int s_bit(input int sr_w);
        return sr_w - 4;
    endfunction

endpackage

// File: rtl/nios2_debug_sync_edge.sv
// Multi-stage synchroniser for an asynchronous level, followed by a registered rising-edge pulse.
module nios2_debug_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            last_q <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~last_q;
        end
    end

endmodule

// File: rtl/nios2_debug_cmd_sysclk_v2.sv
// Captures scan data on update-DR and presents one decoded action strobe under an act_ready handshake.
// Optional DBG_CMD_STATS_EN adds saturating drop/accept counters.
//
//   state | meaning
//   IDLE  | waiting for an update-DR edge
//   ISSUE | strobe presented, waiting for act_ready
//   GAP   | one dead cycle so strobes are never back-to-back
module nios2_debug_cmd_sysclk_v2
    import nios2_debug_pkg::*;
#(
    parameter int SR_W        = DEF_SR_W,
    parameter int IR_W        = 2,
    parameter int NUM_BRK     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int OP_OCIMEM   = DEF_OP_OCIMEM,
    parameter int OP_BREAK    = DEF_OP_BREAK,
    parameter int OP_TRACE    = DEF_OP_TRACE
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [IR_W-1:0]    ir_in,
    input  logic [SR_W-1:0]    sr,
    input  logic               vs_uir,
    input  logic               vs_udr,
    input  logic               act_ready,
    input  logic               overrun_clr,
    output logic [SR_W-1:0]    jdo,
    output logic               take_action_ocimem_a,
    output logic               take_no_action_ocimem_a,
    output logic               take_action_ocimem_b,
    output logic [NUM_BRK-1:0] take_action_break,
    output logic [NUM_BRK-1:0] take_no_action_break,
    output logic               take_action_tracectrl,
    output logic               cmd_pending,
    output logic               overrun
`ifdef DBG_CMD_STATS_EN
    ,
    output logic [15:0]        drop_cnt,
    output logic [15:0]        cmd_cnt
`endif
);

    localparam int MODE_MSB = mode_msb(SR_W);
    localparam int MODE_LSB = mode_lsb(SR_W);
    localparam int T_BIT    = t_bit(SR_W);
    localparam int S_BIT    = s_bit(SR_W);

    logic            uir_e, udr_e;
    dbg_state_t      state;
    logic [IR_W-1:0] ir_lat, cmd_ir;

    logic [IR_W-1:0]    src_ir;
    logic [1:0]         src_ch;
    logic               src_t, src_s;
    logic               nxt_oa, nxt_na, nxt_ob, nxt_tr;
    logic [NUM_BRK-1:0] nxt_ab, nxt_nb;

    nios2_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (vs_uir),
        .rise   (uir_e)
    );

    nios2_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (vs_udr),
        .rise   (udr_e)
    );

    // In IDLE decode the incoming command; otherwise re-decode the held one so strobes stay put
    always_comb begin
        src_ir = cmd_ir;
        src_ch = jdo[MODE_MSB:MODE_LSB];
        src_t  = jdo[T_BIT];
        src_s  = jdo[S_BIT];
        if (state == IDLE) begin
            src_ir = uir_e ? ir_in : ir_lat;
            src_ch = sr[MODE_MSB:MODE_LSB];
            src_t  = sr[T_BIT];
            src_s  = sr[S_BIT];
        end
        nxt_oa = 1'b0;
        nxt_na = 1'b0;
        nxt_ob = 1'b0;
        nxt_tr = 1'b0;
        nxt_ab = '0;
        nxt_nb = '0;
        if (src_ir == IR_W'(OP_OCIMEM)) begin
            nxt_ob = src_t;
            nxt_oa = ~src_t & src_s;
            nxt_na = ~src_t & ~src_s;
        end else if (src_ir == IR_W'(OP_BREAK)) begin
            for (int i = 0; i < NUM_BRK; i++) begin
                if (int'(src_ch) == i) begin
                    nxt_ab[i] = src_t;
                    nxt_nb[i] = ~src_t;
                end
            end
        end else if (src_ir == IR_W'(OP_TRACE)) begin
            nxt_tr = src_t;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= IDLE;
            ir_lat                  <= '0;
            cmd_ir                  <= '0;
            jdo                     <= '0;
            take_action_ocimem_a    <= 1'b0;
            take_no_action_ocimem_a <= 1'b0;
            take_action_ocimem_b    <= 1'b0;
            take_action_break       <= '0;
            take_no_action_break    <= '0;
            take_action_tracectrl   <= 1'b0;
            cmd_pending             <= 1'b0;
            overrun                 <= 1'b0;
        end else begin
            if (uir_e)
                ir_lat <= ir_in;
            if (overrun_clr)
                overrun <= 1'b0;
            if (udr_e && state != IDLE)
                overrun <= 1'b1;

            // Strobes load the decode while a command is live and clear otherwise
            if ((state == IDLE && udr_e) || (state == ISSUE && !act_ready)) begin
                take_action_ocimem_a    <= nxt_oa;
                take_no_action_ocimem_a <= nxt_na;
                take_action_ocimem_b    <= nxt_ob;
                take_action_break       <= nxt_ab;
                take_no_action_break    <= nxt_nb;
                take_action_tracectrl   <= nxt_tr;
            end else begin
                take_action_ocimem_a    <= 1'b0;
                take_no_action_ocimem_a <= 1'b0;
                take_action_ocimem_b    <= 1'b0;
                take_action_break       <= '0;
                take_no_action_break    <= '0;
                take_action_tracectrl   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (udr_e) begin
                        jdo         <= sr;
                        cmd_ir      <= src_ir;
                        cmd_pending <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (act_ready) begin
                        cmd_pending <= 1'b0;
                        state       <= GAP;
                    end
                end
                default: begin
                    cmd_pending <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef DBG_CMD_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
            cmd_cnt  <= '0;
        end else if (overrun_clr) begin
            drop_cnt <= '0;
            cmd_cnt  <= '0;
        end else begin
            if (udr_e && state != IDLE && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            if (state == ISSUE && act_ready && cmd_cnt != 16'hFFFF)
                cmd_cnt <= cmd_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nios2_debug_cmd_sysclk_v2.sv
// Self-checking bench: vector table, random commands against a spec-level model, and handshake corner cases.
module tb_nios2_debug_cmd_sysclk_v2;

    localparam int SR_W = 38;
    localparam int LAT  = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        vs_uir, vs_udr, act_ready, overrun_clr;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [2:0]  take_action_break, take_no_action_break;
    logic        take_action_tracectrl, cmd_pending, overrun;
`ifdef DBG_CMD_STATS_EN
    logic [15:0] drop_cnt, cmd_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] d;
        logic [9:0]  exp;
        int          delay;
    } vec_t;

    vec_t tbl[9];

    nios2_debug_cmd_sysclk_v2 dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .ir_in                  (ir_in),
        .sr                     (sr),
        .vs_uir                 (vs_uir),
        .vs_udr                 (vs_udr),
        .act_ready              (act_ready),
        .overrun_clr            (overrun_clr),
        .jdo                    (jdo),
        .take_action_ocimem_a   (take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b   (take_action_ocimem_b),
        .take_action_break      (take_action_break),
        .take_no_action_break   (take_no_action_break),
        .take_action_tracectrl  (take_action_tracectrl),
        .cmd_pending            (cmd_pending),
        .overrun                (overrun)
`ifdef DBG_CMD_STATS_EN
        ,
        .drop_cnt               (drop_cnt),
        .cmd_cnt                (cmd_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] mk(input bit oa, input bit na, input bit ob,
                                      input bit [2:0] ab, input bit [2:0] nb, input bit tr);
        return {oa, na, ob, ab, nb, tr};
    endfunction

    function automatic logic [9:0] dut_strb();
        return {take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
                take_action_break, take_no_action_break, take_action_tracectrl};
    endfunction

    // Reference decode written straight from the command rules
    function automatic logic [9:0] model(input int ir, input logic [37:0] d);
        int ch = int'(d >> 36);
        bit t  = bit'((d >> 35) & 38'd1);
        bit s  = bit'((d >> 34) & 38'd1);
        case (ir)
            0: return t ? mk(0, 0, 1, 0, 0, 0) : (s ? mk(1, 0, 0, 0, 0, 0) : mk(0, 1, 0, 0, 0, 0));
            2: begin
                if (ch >= 3) return '0;
                return t ? mk(0, 0, 0, 3'(1 << ch), 0, 0) : mk(0, 0, 0, 0, 3'(1 << ch), 0);
            end
            3: return t ? mk(0, 0, 0, 0, 0, 1) : '0;
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, " jdo"}, 64'(jdo), 0);
        chk({nm, " strobes"}, 64'(dut_strb()), 0);
        chk({nm, " cmd_pending"}, 64'(cmd_pending), 0);
        chk({nm, " overrun"}, 64'(overrun), 0);
`ifdef DBG_CMD_STATS_EN
        chk({nm, " drop_cnt"}, 64'(drop_cnt), 0);
        chk({nm, " cmd_cnt"}, 64'(cmd_cnt), 0);
`endif
    endtask

    task automatic set_ir(input logic [1:0] ir);
        ir_in  = ir;
        vs_uir = 1'b1;
        repeat (5) @(negedge clk);
        vs_uir = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_pending(output int n);
        n = 0;
        while (!cmd_pending && n < 12) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_cmd(input string nm, input logic [1:0] ir, input logic [37:0] d,
                          input logic [9:0] exp, input int delay);
        int n;
        set_ir(ir);
        sr        = d;
        act_ready = 1'b0;
        vs_udr    = 1'b1;
        wait_pending(n);
        chk({nm, " latency"}, 64'(n), 64'(LAT));
        chk({nm, " jdo"}, 64'(jdo), 64'(d));
        for (int k = 0; k <= delay; k++) begin
            chk({nm, " strobes"}, 64'(dut_strb()), 64'(exp));
            chk({nm, " pending"}, 64'(cmd_pending), 1);
            if (k < delay) @(negedge clk);
        end
        act_ready = 1'b1;
        @(negedge clk);
        act_ready = 1'b0;
        n_acc++;
        chk({nm, " strobes off"}, 64'(dut_strb()), 0);
        chk({nm, " pending off"}, 64'(cmd_pending), 0);
        chk({nm, " no overrun"}, 64'(overrun), 0);
        vs_udr = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int n;
        logic [63:0] r;
        logic [1:0]  rir;
        logic [37:0] rd;

        tbl[0] = '{2'd0, 38'h04_1234_5678, mk(1, 0, 0, 0, 0, 0), 0};
        tbl[1] = '{2'd0, 38'h08_0000_00AB, mk(0, 0, 1, 0, 0, 0), 1};
        tbl[2] = '{2'd0, 38'h00_DEAD_BEEF, mk(0, 1, 0, 0, 0, 0), 0};
        tbl[3] = '{2'd2, 38'h18_0000_0001, mk(0, 0, 0, 3'b010, 0, 0), 5};
        tbl[4] = '{2'd2, 38'h38_0000_0000, '0, 0};
        tbl[5] = '{2'd2, 38'h20_0000_0002, mk(0, 0, 0, 0, 3'b100, 0), 2};
        tbl[6] = '{2'd3, 38'h08_0000_0003, mk(0, 0, 0, 0, 0, 1), 0};
        tbl[7] = '{2'd3, 38'h07_0000_0000, '0, 1};
        tbl[8] = '{2'd1, 38'h3F_FFFF_FFFF, '0, 0};

        reset_n     = 1'b0;
        ir_in       = '0;
        sr          = '0;
        vs_uir      = 1'b0;
        vs_udr      = 1'b0;
        act_ready   = 1'b0;
        overrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++)
            do_cmd($sformatf("vec%0d", i), tbl[i].ir, tbl[i].d, tbl[i].exp, tbl[i].delay);
`ifdef DBG_CMD_STATS_EN
        chk("cmd_cnt after table", 64'(cmd_cnt), 64'(n_acc));
`endif

        for (int i = 0; i < 24; i++) begin
            r   = {$urandom(), $urandom()};
            rd  = r[37:0];
            rir = 2'($urandom_range(0, 3));
            do_cmd($sformatf("rnd%0d", i), rir, rd, model(int'(rir), rd), int'($urandom_range(0, 3)));
        end
`ifdef DBG_CMD_STATS_EN
        chk("cmd_cnt after random", 64'(cmd_cnt), 64'(n_acc));
`endif

        // Second update while a command is still pending
        set_ir(2'd2);
        sr        = 38'h18_0000_0055;
        act_ready = 1'b0;
        vs_udr    = 1'b1;
        wait_pending(n);
        chk("ovr first latency", 64'(n), 64'(LAT));
        vs_udr = 1'b0;
        repeat (5) @(negedge clk);
        sr     = 38'h08_0000_0000;
        vs_udr = 1'b1;
        repeat (6) @(negedge clk);
        chk("ovr flag", 64'(overrun), 1);
        chk("ovr jdo kept", 64'(jdo), 64'h18_0000_0055);
        chk("ovr pending", 64'(cmd_pending), 1);
        chk("ovr strobes kept", 64'(dut_strb()), 64'(mk(0, 0, 0, 3'b010, 0, 0)));
`ifdef DBG_CMD_STATS_EN
        chk("ovr drop_cnt", 64'(drop_cnt), 1);
`endif
        overrun_clr = 1'b1;
        vs_udr      = 1'b0;
        repeat (5) @(negedge clk);
        chk("ovr cleared", 64'(overrun), 0);
        vs_udr = 1'b1;
        repeat (4) @(negedge clk);
        chk("ovr set beats clear", 64'(overrun), 1);
        @(negedge clk);
        chk("ovr clear next", 64'(overrun), 0);
`ifdef DBG_CMD_STATS_EN
        chk("drop clear beats inc", 64'(drop_cnt), 0);
`endif
        overrun_clr = 1'b0;
        act_ready   = 1'b1;
        @(negedge clk);
        act_ready = 1'b0;
        chk("ovr drained", 64'(cmd_pending), 0);
        chk("ovr jdo final", 64'(jdo), 64'h18_0000_0055);
        vs_udr = 1'b0;
        repeat (6) @(negedge clk);
`ifdef DBG_CMD_STATS_EN
        chk("cmd_cnt after clear", 64'(cmd_cnt), 1);
`endif
        n_acc = 1;

        // Simultaneous uir and udr: the fresh IR must win over the latched one
        set_ir(2'd0);
        ir_in     = 2'd3;
        sr        = 38'h08_0000_0000;
        act_ready = 1'b0;
        vs_uir    = 1'b1;
        vs_udr    = 1'b1;
        wait_pending(n);
        chk("simul latency", 64'(n), 64'(LAT));
        chk("simul strobes", 64'(dut_strb()), 64'(mk(0, 0, 0, 0, 0, 1)));
        act_ready = 1'b1;
        @(negedge clk);
        act_ready = 1'b0;
        chk("simul strobes off", 64'(dut_strb()), 0);
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        repeat (6) @(negedge clk);

        // Reset while a command is being presented
        set_ir(2'd0);
        sr        = 38'h04_0000_0001;
        act_ready = 1'b0;
        vs_udr    = 1'b1;
        wait_pending(n);
        chk("rst pre pending", 64'(cmd_pending), 1);
        reset_n = 1'b0;
        vs_udr  = 1'b0;
        #1;
        check_all_zero("mid reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n_acc   = 0;
        repeat (2) @(negedge clk);
        do_cmd("post reset", 2'd0, 38'h04_0000_0001, mk(1, 0, 0, 0, 0, 0), 0);
`ifdef DBG_CMD_STATS_EN
        chk("cmd_cnt post reset", 64'(cmd_cnt), 64'(n_acc));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
